// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: NES CPU-side bus decode, mirror folding, MDR/MAR latches, cart wait states.
// Optional OAM DMA engine at $4014 is built in when MEMBUS_OAM_DMA_EN is defined.
module mem_bus_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int RAM_AW    = 11,
  parameter int PPU_AW    = 3,
  parameter int CART_WAIT = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              r,
  input  logic              w,
  input  logic              MEM_LDMDRL,
  input  logic              MEM_LDMDRH,
  input  logic              MEM_LDMAR,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] ppu_reg_data,
  input  logic [DATA_W-1:0] gamepad_data,
  input  logic [DATA_W-1:0] cart_data,
  output logic              ready,
  output logic              dma_busy,
  output logic [DATA_W-1:0] MDRL,
  output logic [DATA_W-1:0] MDRH,
  output logic [ADDR_W-1:0] MAR,
  output logic [ADDR_W-1:0] dev_addr,
  output logic [DATA_W-1:0] dev_wdata,
  output logic              mem_r,
  output logic              mem_w,
  output logic              ppu_reg_r,
  output logic              ppu_reg_w,
  output logic              gamepad_r,
  output logic              gamepad_w,
  output logic              cart_r,
  output logic              cart_w
);

  // state     | meaning
  // S_IDLE    | CPU access decode, internal devices complete this cycle
  // S_CART_WT | cartridge wait states, strobe held until counter hits 1
  // S_DMA_RD  | OAM DMA source read of {page, index}
  // S_DMA_WR  | OAM DMA write of captured byte to PPU $2004
  typedef enum logic [1:0] {S_IDLE, S_CART_WT, S_DMA_RD, S_DMA_WR} state_t;
  typedef enum logic [2:0] {T_MEM, T_PPU, T_PAD, T_CART, T_NONE, T_DMA} tgt_t;

`ifdef MEMBUS_OAM_DMA_EN
  localparam bit DMA_EN = 1'b1;
`else
  localparam bit DMA_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] mdrl_q, mdrl_d, mdrh_q, mdrh_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] bus_addr, fold_addr;
  logic [DATA_W-1:0] rdata_sel;
  tgt_t              tgt;
  logic              req, in_dma, rd_stb, wr_stb;

  assign req    = r | w;
  assign in_dma = (state_q == S_DMA_RD) || (state_q == S_DMA_WR);

`ifdef MEMBUS_OAM_DMA_EN
  logic [DATA_W-1:0] page_q, page_d, byte_q, byte_d;
  logic [7:0]        index_q, index_d;

  assign bus_addr = (state_q == S_DMA_RD) ? ADDR_W'({page_q, index_q}) : addr;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      page_q  <= '0;
      index_q <= '0;
      byte_q  <= '0;
    end else begin
      page_q  <= page_d;
      index_q <= index_d;
      byte_q  <= byte_d;
    end
  end
`else
  assign bus_addr = addr;
`endif

  always_comb begin
    tgt       = T_NONE;
    fold_addr = '0;
    rdata_sel = '0;
    if (bus_addr < ADDR_W'(16'h2000)) begin
      tgt       = T_MEM;
      fold_addr = ADDR_W'(bus_addr[RAM_AW-1:0]);
      rdata_sel = mem_data;
    end else if (bus_addr < ADDR_W'(16'h4000)) begin
      tgt       = T_PPU;
      fold_addr = ADDR_W'(bus_addr[PPU_AW-1:0]);
      rdata_sel = ppu_reg_data;
    end else if (bus_addr == ADDR_W'(16'h4016) || bus_addr == ADDR_W'(16'h4017)) begin
      tgt       = T_PAD;
      fold_addr = ADDR_W'(bus_addr[0]);
      rdata_sel = gamepad_data;
    end else if (bus_addr == ADDR_W'(16'h4014)) begin
      // a DMA source page of $40 reads $4014 as a plain PPU register
      if (DMA_EN && !in_dma) begin
        tgt = T_DMA;
      end else begin
        tgt       = T_PPU;
        fold_addr = ADDR_W'(4);
        rdata_sel = ppu_reg_data;
      end
    end else if (bus_addr >= ADDR_W'(16'h4020)) begin
      tgt       = T_CART;
      fold_addr = bus_addr;
      rdata_sel = cart_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mdrl_q  <= '0;
      mdrh_q  <= '0;
      mar_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mdrl_q  <= mdrl_d;
      mdrh_q  <= mdrh_d;
      mar_q   <= mar_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef MEMBUS_OAM_DMA_EN
    page_d  = page_q;
    index_d = index_q;
    byte_d  = byte_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req && tgt == T_CART && CART_WAIT != 0) begin
          state_d = S_CART_WT;
          cnt_d   = 4'(CART_WAIT);
        end
`ifdef MEMBUS_OAM_DMA_EN
        else if (w && tgt == T_DMA) begin
          state_d = S_DMA_RD;
          page_d  = wdata;
          index_d = '0;
        end
`endif
      end
      S_CART_WT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_IDLE;
      end
`ifdef MEMBUS_OAM_DMA_EN
      S_DMA_RD: begin
        // counter is 0 on entry; first cart cycle arms it, ready at 1
        if (tgt == T_CART && CART_WAIT != 0) begin
          cnt_d = (cnt_q == 4'd0) ? 4'(CART_WAIT) : cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            byte_d  = rdata_sel;
            state_d = S_DMA_WR;
          end
        end else begin
          byte_d  = rdata_sel;
          state_d = S_DMA_WR;
        end
      end
      S_DMA_WR: begin
        index_d = index_q + 8'd1;
        state_d = (index_q == 8'hFF) ? S_IDLE : S_DMA_RD;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    rd_stb    = 1'b0;
    wr_stb    = 1'b0;
    dev_addr  = fold_addr;
    dev_wdata = wdata;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          rd_stb = ~w;
          wr_stb = w;
          ready  = !(tgt == T_CART && CART_WAIT != 0);
        end
      end
      S_CART_WT: begin
        rd_stb = ~w;
        wr_stb = w;
        ready  = (cnt_q == 4'd1);
      end
      S_DMA_RD: rd_stb = 1'b1;
      default: ;
    endcase
    mem_r     = rd_stb && tgt == T_MEM;
    mem_w     = wr_stb && tgt == T_MEM;
    ppu_reg_r = rd_stb && tgt == T_PPU;
    ppu_reg_w = wr_stb && tgt == T_PPU;
    gamepad_r = rd_stb && tgt == T_PAD;
    gamepad_w = wr_stb && tgt == T_PAD;
    cart_r    = rd_stb && tgt == T_CART;
    cart_w    = wr_stb && tgt == T_CART;
`ifdef MEMBUS_OAM_DMA_EN
    if (state_q == S_DMA_WR) begin
      ppu_reg_w = 1'b1;
      dev_addr  = ADDR_W'(4);
      dev_wdata = byte_q;
    end
`endif
    dma_busy = in_dma;
    if (!RESET_N) begin
      ready     = 1'b0;
      dma_busy  = 1'b0;
      mem_r     = 1'b0;
      mem_w     = 1'b0;
      ppu_reg_r = 1'b0;
      ppu_reg_w = 1'b0;
      gamepad_r = 1'b0;
      gamepad_w = 1'b0;
      cart_r    = 1'b0;
      cart_w    = 1'b0;
    end
  end

  always_comb begin
    mdrl_d = (ready && MEM_LDMDRL) ? rdata_sel : mdrl_q;
    mdrh_d = (ready && MEM_LDMDRH) ? rdata_sel : mdrh_q;
    mar_d  = MEM_LDMAR ? addr : mar_q;
  end

  assign MDRL = mdrl_q;
  assign MDRH = mdrh_q;
  assign MAR  = mar_q;

endmodule
